// File: rtl/mtm_alu_pkg.sv
`default_nettype none
// ============================================================================
// mtm_alu_pkg
// Shared MTM ALU types and constants, plus the crc4_68 function.
// Revision: 1.0
// ============================================================================
package mtm_alu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101
  } op_e;

  localparam int ERR_DATA_BIT = 2;
  localparam int ERR_CRC_BIT  = 1;
  localparam int ERR_OP_BIT   = 0;

  localparam logic [3:0] DATA_PKTS   = 4'd8;
  localparam logic [3:0] PKT_CNT_MAX = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FLAG   = 3'd1,
    ST_BITS   = 3'd2,
    ST_STOP   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_RESYNC = 3'd5
  } rx_state_e;

  // Serial CRC, x^4+x+1, init 0, data taken MSB first.
  function automatic logic [3:0] crc4_68(input logic [67:0] d);
    logic [3:0] c;
    logic       fb;
    c = 4'd0;
    for (int i = 67; i >= 0; i--) begin
      fb = d[i] ^ c[3];
      c  = {c[2], c[1], c[0] ^ fb, fb};
    end
    return c;
  endfunction

  function automatic logic op_is_valid(input logic [2:0] op);
    return op inside {OP_AND, OP_OR, OP_ADD, OP_SUB};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mtm_alu_rx_byte.sv
`default_nettype none
// ============================================================================
// mtm_alu_rx_byte
// Packet receiver: start 0, flag, 8 bits MSB first, stop 1.
// Revision: 1.0
// ============================================================================
module mtm_alu_rx_byte
  import mtm_alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sin_i,
  output logic [7:0] byte_o,
  output logic       flag_o,
  output logic       byte_valid_o,
  output logic       frame_err_o,
  output logic       idle_o
);

  rx_state_e  state_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] byte_q;
  logic       flag_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 3'd0;
      byte_q    <= 8'd0;
      flag_q    <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (!sin_i) state_q <= ST_FLAG;
        ST_FLAG: begin
          flag_q    <= sin_i;
          bit_cnt_q <= 3'd7;
          state_q   <= ST_BITS;
        end
        ST_BITS: begin
          byte_q    <= {byte_q[6:0], sin_i};
          bit_cnt_q <= bit_cnt_q - 3'd1;
          if (bit_cnt_q == 3'd0) state_q <= ST_STOP;
        end
        ST_STOP: begin
          if (!sin_i)      state_q <= ST_RESYNC;
          else if (flag_q) state_q <= ST_CHECK;
          else             state_q <= ST_IDLE;
        end
        // The line is ignored for one cycle after a ctl packet.
        ST_CHECK:  state_q <= ST_IDLE;
        ST_RESYNC: if (sin_i) state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  // Stop-bit strobes are decoded while the stop bit is on the line so the
  // parent can register its result on the same edge that samples it.
  assign byte_o       = byte_q;
  assign flag_o       = flag_q;
  assign byte_valid_o = (state_q == ST_STOP) && sin_i;
  assign frame_err_o  = (state_q == ST_STOP) && !sin_i;
  assign idle_o       = (state_q == ST_IDLE);

endmodule
`default_nettype wire

// File: rtl/mtm_alu_deserializer.sv
`default_nettype none
// ============================================================================
// mtm_alu_deserializer
// MTM ALU receive stage: packet counting, CRC/opcode checks, operand output.
// Optional inter-packet timeout: define MTM_DESER_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
module mtm_alu_deserializer
  import mtm_alu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [2:0]  OP,
  output logic [2:0]  err_flags,
  output logic        out_valid
);

  logic [7:0]  rx_byte;
  logic        rx_flag;
  logic        rx_byte_valid;
  logic        rx_frame_err;
  logic        rx_idle;

  logic [63:0] ba_q;
  logic [3:0]  pkt_cnt_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [2:0]  op_q;
  logic [2:0]  err_q;
  logic        valid_q;

  logic [2:0]  check_flags;
  logic        crc_ok;
  logic        timeout;
  logic        unused_ok;

  mtm_alu_rx_byte u_rx (
    .clk          (clk),
    .rst_n        (rst_n),
    .sin_i        (sin),
    .byte_o       (rx_byte),
    .flag_o       (rx_flag),
    .byte_valid_o (rx_byte_valid),
    .frame_err_o  (rx_frame_err),
    .idle_o       (rx_idle)
  );

  assign crc_ok = (crc4_68({ba_q, 1'b1, rx_byte[6:4]}) == rx_byte[3:0]);

  always_comb begin
    check_flags = 3'b000;
    if (pkt_cnt_q != DATA_PKTS)         check_flags[ERR_DATA_BIT] = 1'b1;
    else if (!crc_ok)                   check_flags[ERR_CRC_BIT]  = 1'b1;
    else if (!op_is_valid(rx_byte[6:4])) check_flags[ERR_OP_BIT]   = 1'b1;
  end

`ifdef MTM_DESER_TIMEOUT_EN
  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [GAP_W-1:0] gap_q;

  assign timeout = rx_idle && (pkt_cnt_q != 4'd0) && (gap_q == GAP_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || !rx_idle || (pkt_cnt_q == 4'd0) || timeout) gap_q <= '0;
    else                                                      gap_q <= gap_q + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ba_q      <= 64'd0;
      pkt_cnt_q <= 4'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      op_q      <= 3'd0;
      err_q     <= 3'd0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (rx_frame_err) begin
        valid_q   <= 1'b1;
        err_q     <= 3'b100;
        pkt_cnt_q <= 4'd0;
      end else if (rx_byte_valid && !rx_flag) begin
        ba_q <= {ba_q[55:0], rx_byte};
        if (pkt_cnt_q != PKT_CNT_MAX) pkt_cnt_q <= pkt_cnt_q + 4'd1;
      end else if (rx_byte_valid && rx_flag) begin
        valid_q   <= 1'b1;
        err_q     <= check_flags;
        pkt_cnt_q <= 4'd0;
        // Operands are only replaced by a clean frame.
        if (check_flags == 3'b000) begin
          b_q  <= ba_q[63:32];
          a_q  <= ba_q[31:0];
          op_q <= rx_byte[6:4];
        end
      end else if (timeout) begin
        valid_q   <= 1'b1;
        err_q     <= 3'b100;
        pkt_cnt_q <= 4'd0;
      end
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign OP        = op_q;
  assign err_flags = err_q;
  assign out_valid = valid_q;

  assign unused_ok = &{1'b0, rx_byte[7], rx_idle, (TIMEOUT_CYCLES > 0)};

endmodule
`default_nettype wire

// File: tb/tb_mtm_alu_deserializer.sv
`default_nettype none
// ============================================================================
// tb_mtm_alu_deserializer
// Packet-level model of the MTM ALU receive stage with a per-cycle compare.
// Revision: 1.0
// ============================================================================
module tb_mtm_alu_deserializer;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sin;
  logic [31:0] A, B;
  logic [2:0]  OP, err_flags;
  logic        out_valid;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0]  err;
    logic [31:0] b;
    logic [31:0] a;
    logic [2:0]  op;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  m_bytes[$];
  int          m_cnt = 0;
  logic [31:0] m_a = 0, m_b = 0;
  logic [2:0]  m_op = 0, m_err = 0;

  mtm_alu_deserializer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin),
    .A         (A),
    .B         (B),
    .OP        (OP),
    .err_flags (err_flags),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Remainder of M(x)*x^4 divided by x^4+x+1, by long division.
  function automatic logic [3:0] model_crc(input logic [67:0] m);
    logic [71:0] v;
    v = {m, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (v[i]) v[i-:5] = v[i-:5] ^ 5'b10011;
    return v[3:0];
  endfunction

  function automatic logic [63:0] cur_ba();
    logic [63:0] r;
    r = 64'd0;
    for (int i = 0; i < m_bytes.size(); i++) r = {r[55:0], m_bytes[i]};
    return r;
  endfunction

  task automatic send_bit(input logic b);
    sin = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) send_bit(1'b1);
  endtask

  task automatic send_pkt(input logic flag, input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    send_bit(flag);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic data_byte(input logic [7:0] d);
    send_pkt(1'b0, d, 1'b1);
    m_bytes.push_back(d);
    if (m_bytes.size() > 8) void'(m_bytes.pop_front());
    if (m_cnt < 9) m_cnt++;
    idle($urandom_range(0, 3));
  endtask

  task automatic ctl(input logic [2:0] op, input logic [3:0] crc);
    exp_t        e;
    logic [63:0] ba;
    send_pkt(1'b1, {1'b0, op, crc}, 1'b1);
    ba = cur_ba();
    e.b = ba[63:32];
    e.a = ba[31:0];
    e.op = op;
    if (m_cnt != 8)                                   e.err = 3'b100;
    else if (crc != model_crc({ba, 1'b1, op}))        e.err = 3'b010;
    else if (!(op inside {3'b000, 3'b001, 3'b100, 3'b101})) e.err = 3'b001;
    else                                              e.err = 3'b000;
    exp_q.push_back(e);
    m_cnt = 0;
    idle(2 + $urandom_range(0, 2));
  endtask

  task automatic ctl_auto(input logic [2:0] op);
    ctl(op, model_crc({cur_ba(), 1'b1, op}));
  endtask

  task automatic bad_data(input logic [7:0] d);
    send_pkt(1'b0, d, 1'b0);
    exp_q.push_back('{err: 3'b100, b: 32'd0, a: 32'd0, op: 3'd0});
    m_cnt = 0;
    idle(3);
  endtask

  task automatic send_frame(input logic [31:0] b, input logic [31:0] a,
                            input logic [2:0] op, input logic [3:0] crc);
    logic [63:0] ba;
    ba = {b, a};
    for (int i = 7; i >= 0; i--) data_byte(ba[i*8+:8]);
    ctl(op, crc);
  endtask

  task automatic stall(input int n);
`ifdef MTM_DESER_TIMEOUT_EN
    if (m_cnt != 0 && n >= TO) begin
      idle(TO);
      exp_q.push_back('{err: 3'b100, b: 32'd0, a: 32'd0, op: 3'd0});
      m_cnt = 0;
      idle(n - TO);
    end else idle(n);
`else
    idle(n);
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    m_cnt = 0;
    m_bytes.delete();
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      m_a = 0; m_b = 0; m_op = 0; m_err = 0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: out_valid=1 with no frame pending");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          m_err = e.err;
          if (e.err == 3'b000) begin
            m_a = e.a; m_b = e.b; m_op = e.op;
          end
        end
      end
      chk("outputs", 96'({A, B, OP, err_flags}), 96'({m_a, m_b, m_op, m_err}));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  rop;
    int          kind, k;
    rst_n = 1'b0;
    sin   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 96'(out_valid), 96'd0);
    chk("rst_outputs", 96'({A, B, OP, err_flags}), 96'd0);
    rst_n = 1'b1;
    idle(3);

    // Hand-computed CRCs: x^7 mod g = 1011, x^7+x^4 mod g = 1000.
    send_frame(32'd0, 32'd0, 3'b000, 4'hB);
    chk("pin_crc_b_err", 96'(err_flags), 96'd0);
    send_frame(32'd0, 32'd0, 3'b001, 4'h8);
    chk("pin_crc_8_err", 96'(err_flags), 96'd0);
    chk("pin_crc_8_op", 96'(OP), 96'd1);

    send_frame(32'h2, 32'h1, 3'b100, 4'hC);
    chk("t1_A", 96'(A), 96'd1);
    chk("t1_B", 96'(B), 96'd2);
    chk("t1_OP", 96'(OP), 96'd4);
    chk("t1_err", 96'(err_flags), 96'd0);

    send_frame(32'h2, 32'h1, 3'b100, 4'hD);
    chk("t2_err", 96'(err_flags), 96'b010);
    chk("t2_A", 96'(A), 96'd1);
    chk("t2_OP", 96'(OP), 96'd4);

    send_frame(32'h5, 32'h6, 3'b010, model_crc({32'h5, 32'h6, 1'b1, 3'b010}));
    chk("t3_err", 96'(err_flags), 96'b001);

    for (int i = 0; i < 7; i++) data_byte(8'(i + 16));
    ctl_auto(3'b000);
    chk("t4_short_err", 96'(err_flags), 96'b100);
    data_byte(8'hAA);
    send_frame(32'h77, 32'h88, 3'b001, model_crc({32'h77, 32'h88, 1'b1, 3'b001}));
    chk("t4_long_err", 96'(err_flags), 96'b100);
    chk("t4_long_A", 96'(A), 96'd1);

    data_byte(8'h11);
    data_byte(8'h22);
    bad_data(8'h33);
    chk("t5_frame_err", 96'(err_flags), 96'b100);
    send_frame(32'hDEADBEEF, 32'h12345678, 3'b101,
               model_crc({32'hDEADBEEF, 32'h12345678, 1'b1, 3'b101}));
    chk("t5_A", 96'(A), 96'h12345678);
    chk("t5_B", 96'(B), 96'hDEADBEEF);
    chk("t5_err", 96'(err_flags), 96'd0);

    for (int i = 0; i < 4; i++) data_byte(8'hC0 + 8'(i));
    do_reset();
    chk("t6_valid", 96'(out_valid), 96'd0);
    chk("t6_outputs", 96'({A, B, OP, err_flags}), 96'd0);
    send_frame(32'hCAFE0001, 32'h0BADF00D, 3'b000,
               model_crc({32'hCAFE0001, 32'h0BADF00D, 1'b1, 3'b000}));
    chk("t6_A", 96'(A), 96'h0BADF00D);

    for (int i = 0; i < 5; i++) data_byte(8'h50 + 8'(i));
    stall(TO);
    for (int i = 0; i < 3; i++) data_byte(8'h60 + 8'(i));
    ctl_auto(3'b100);
`ifdef MTM_DESER_TIMEOUT_EN
    chk("t7_err", 96'(err_flags), 96'b100);
`else
    chk("t7_err", 96'(err_flags), 96'd0);
`endif
    chk("t7_pending", 96'(exp_q.size()), 96'd0);

    for (int n = 0; n < 25; n++) begin
      ra   = $urandom;
      rb   = $urandom;
      rop  = 3'($urandom_range(0, 7));
      kind = $urandom_range(0, 9);
      case (kind)
        0: begin
          for (int i = 0; i < 7; i++) data_byte(8'($urandom));
          ctl_auto(rop);
        end
        1: begin
          data_byte(8'($urandom));
          send_frame(rb, ra, rop, model_crc({rb, ra, 1'b1, rop}));
        end
        2: begin
          k = $urandom_range(0, 7);
          for (int i = 0; i < k; i++) data_byte(8'($urandom));
          bad_data(8'($urandom));
        end
        3: send_frame(rb, ra, rop,
                      model_crc({rb, ra, 1'b1, rop}) ^ 4'($urandom_range(1, 15)));
        default: send_frame(rb, ra, rop, model_crc({rb, ra, 1'b1, rop}));
      endcase
    end

    idle(10);
    chk("final_pending", 96'(exp_q.size()), 96'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mtm_alu_deserializer.md
Name: mtm_alu_deserializer

Overview:
- Receive stage of the MTM ALU. Samples the serial input line `sin` one bit per `clk` and reassembles B and A operands plus the control packet.
- Checks framing, packet count, CRC4 and opcode.
- Presents operands, opcode and one-hot error flags to the ALU core with a single-cycle `out_valid`. The core then builds C/CTL_out for the output serializer.
- Line format is identical to the serializer's: start 0, flag (0 = data, 1 = ctl), 8 bits MSB first, stop 1. Idle line is high.

Parameters:
- `TIMEOUT_CYCLES`, 64: maximum idle-high cycles allowed between packets inside a frame. Used only with `MTM_DESER_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `sin`  in  1  serial input, idle high
- `A`  out  32  operand A (registered)
- `B`  out  32  operand B (registered)
- `OP`  out  3  opcode (registered)
- `err_flags`  out  3  one-hot {ERR_DATA, ERR_CRC, ERR_OP}; 000 = good frame
- `out_valid`  out  1  one-cycle pulse; `A`/`B`/`OP`/`err_flags` are valid that cycle

Behaviour:
- Reset: all outputs 0, FSM to IDLE, packet counter 0, shift registers cleared.
  - Reset mid-frame discards the partial frame with no `out_valid`.
- Frame: 8 data packets, then 1 ctl packet.
  - Data packets in order B[31:24], B[23:16], B[15:8], B[7:0], A[31:24] … A[7:0]; bits MSB first.
  - Ctl byte = {1'b0, OP[2:0], CRC[3:0]}.
- FSM states: IDLE, FLAG, BITS, STOP, CHECK, RESYNC.
  - IDLE: `sin`==0 -> FLAG (start bit). Otherwise stay.
  - FLAG: latch the flag bit, load bit counter 7 -> BITS.
  - BITS: shift `sin` into the byte register; at counter 0 -> STOP.
  - STOP, `sin`==0 (framing error): pulse `out_valid` next cycle with `err_flags`=100 -> RESYNC.
  - STOP, `sin`==1, data packet: shift the byte into the 64-bit {B,A} register; packet counter +1, saturating at 9 -> IDLE.
  - STOP, `sin`==1, ctl packet -> CHECK.
  - CHECK (one cycle): evaluate errors, assert `out_valid`, clear packet counter -> IDLE.
  - RESYNC: wait for `sin`==1, clear packet counter -> IDLE.
- Error priority in CHECK (exactly one flag set):
  - ERR_DATA if packet counter != 8 (covers both too few and too many data packets).
  - Otherwise ERR_CRC if received CRC != crc4 over {B, A, 1'b1, OP}: 68 bits, poly x^4+x+1, init 0.
  - Otherwise ERR_OP if OP is not one of AND 000, OR 001, ADD 100, SUB 101.
  - Otherwise 000.
- `A`/`B`/`OP` update only on error-free frames and hold their previous values on error. `err_flags` updates on every `out_valid`.
- Latency: `out_valid` is high in the cycle after the ctl stop bit is sampled.
  - A new start bit may arrive in the CHECK cycle. It is sampled by IDLE the next cycle, so a gap of ≥1 idle bit is required; the serializer guarantees this.
- `out_valid` is never high for two consecutive cycles.

Optional Feature:
- Macro: `MTM_DESER_TIMEOUT_EN`.
- Enabled: a gap counter runs while in IDLE with packet counter != 0. Reaching `TIMEOUT_CYCLES` pulses `out_valid` with ERR_DATA and clears the packet counter.
- Disabled: no counter; a partial frame waits indefinitely.

Decomposition:
- Package `mtm_alu_pkg` holds:
  - opcode enum: AND, OR, ADD, SUB;
  - error bit indices;
  - the `crc4_68` function, shared with the core's CRC3 logic area;
  - FSM state typedef;
  - packet-count constant 8.
- One natural sub-module: `mtm_alu_rx_byte` (start/flag/8 bits/stop receiver emitting byte, flag, byte_valid, frame_err); the top holds packet counting and checks.

Test Plan:
1. Good frame, A=32'h00000001, B=32'h00000002, OP=100, correct CRC -> one `out_valid`, A=1, B=2, OP=100, `err_flags`=000.
2. Same frame with CRC bit 0 flipped -> `err_flags`=010, A/B/OP unchanged from the previous good frame.
3. Valid CRC computed for OP=010 -> `err_flags`=001.
4. Ctl packet after 7 data packets, and separately after 9 -> `err_flags`=100 both times.
5. Stop bit driven 0 on the 3rd data packet -> `err_flags`=100, then RESYNC; the next good frame is decoded correctly.
6. Reset asserted mid-frame (after 4 data packets) -> no `out_valid`, outputs 0; the following good frame is decoded.
7. Timeout, with `MTM_DESER_TIMEOUT_EN`: stall 64 cycles after packet 5 -> ERR_DATA pulse.
